// File: rtl/sipo_deser.sv
// sipo_deser: serial-in, parallel-out deserializer with a one-word output buffer.
// Bits arrive LSB first, qualified by sin_valid. Each completed word is handed to
// a valid/ready consumer. A word that completes while the buffer is still held
// is dropped, and the sticky overrun flag records the loss.
module sipo_deser #(
  parameter int WIDTH = 10,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  typedef enum logic {IDLE, SHIFT} rx_state_t;
  typedef enum logic {EMPTY, FULL} buf_state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_t        rx_state;
  buf_state_t       buf_state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] new_word;
  logic             complete;
  logic             load;
  logic             consume;

  // The completed word includes the bit being sampled on this edge. The buffer
  // takes it if the buffer is empty, or if the consumer drains the buffer on the same edge.
  always_comb begin
    new_word = {sin, sr[WIDTH-1:1]};
    complete = sin_valid && (bit_cnt == LAST);
    load     = complete && ((buf_state == EMPTY) || dout_ready);
    consume  = (buf_state == FULL) && dout_ready;
  end

  // Receive shifter, bit counter, output buffer and overrun flag, all held in one register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= IDLE;
      buf_state  <= EMPTY;
      sr         <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      rx_state   <= IDLE;
      buf_state  <= EMPTY;
      sr         <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (sin_valid) begin
        sr <= new_word;
        if (rx_state == IDLE) begin
          bit_cnt  <= CW'(1);
          rx_state <= SHIFT;
        end else if (bit_cnt == LAST) begin
          bit_cnt  <= '0;
          rx_state <= IDLE;
        end else begin
          bit_cnt  <= bit_cnt + CW'(1);
          rx_state <= SHIFT;
        end
      end

      if (load) begin
        dout       <= new_word;
        dout_valid <= 1'b1;
        buf_state  <= FULL;
      end else if (consume) begin
        dout_valid <= 1'b0;
        buf_state  <= EMPTY;
      end

      if (complete && !load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed bench for sipo_deser. A 4-bit instance carries most of
// the scenarios, and a default-width (10-bit) instance carries the wide-word case.
// Stimulus queues each expected word. Monitors pop and compare the words as they appear.
module tb_sipo_deser;

  logic       clk;
  logic       rst;
  logic       clear;

  logic       sin, sin_valid, dout_ready;
  logic [3:0] dout;
  logic       dout_valid, overrun;
  logic [1:0] bit_cnt;

  logic       sin10, sin_valid10, dout_ready10;
  logic [9:0] dout10;
  logic       dout_valid10, overrun10;
  logic [3:0] bit_cnt10;

  int checks = 0;
  int errors = 0;

  logic [3:0] q4[$];
  logic [9:0] q10[$];

  logic prev_valid4 = 1'b0, prev_ready4 = 1'b0;
  logic prev_valid10 = 1'b0, prev_ready10 = 1'b0;

  sipo_deser #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .bit_cnt(bit_cnt), .overrun(overrun)
  );

  sipo_deser dut10 (
    .clk(clk), .rst(rst), .sin(sin10), .sin_valid(sin_valid10), .clear(clear),
    .dout(dout10), .dout_valid(dout_valid10), .dout_ready(dout_ready10),
    .bit_cnt(bit_cnt10), .overrun(overrun10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one accepted bit for exactly one clock edge, on either instance.
  task automatic applyStimulus(input logic b, input bit wide);
    if (wide) begin
      sin10 = b; sin_valid10 = 1'b1;
    end else begin
      sin = b; sin_valid = 1'b1;
    end
    @(posedge clk); #1;
    sin_valid = 1'b0;
    sin_valid10 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Detect each newly loaded word: valid is now high, and the previous edge either saw the buffer empty or a consume.
  always @(negedge clk) begin
    if (rst && dout_valid && (!prev_valid4 || prev_ready4)) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL dout4_unexpected: got %0h expected none", dout);
      end else begin
        checkOutput("dout4_word", dout, q4.pop_front());
      end
    end
    if (rst && dout_valid10 && (!prev_valid10 || prev_ready10)) begin
      if (q10.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL dout10_unexpected: got %0h expected none", dout10);
      end else begin
        checkOutput("dout10_word", dout10, q10.pop_front());
      end
    end
    prev_valid4  = dout_valid;
    prev_ready4  = dout_ready;
    prev_valid10 = dout_valid10;
    prev_ready10 = dout_ready10;
  end

  initial begin
    logic [3:0] bits;
    logic [1:0] cnt;
    rst = 1'b0; clear = 1'b0;
    sin = 1'b1; sin_valid = 1'b1; dout_ready = 1'b0;
    sin10 = 1'b1; sin_valid10 = 1'b1; dout_ready10 = 1'b0;

    // Reset held with bits offered: nothing may move.
    #23;
    checkOutput("rst_bit_cnt", 32'(bit_cnt), 0);
    checkOutput("rst_dout", 32'(dout), 0);
    checkOutput("rst_valid", 32'(dout_valid), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_bit_cnt10", 32'(bit_cnt10), 0);
    @(posedge clk); #1;
    sin_valid = 1'b0; sin_valid10 = 1'b0; sin = 1'b0; sin10 = 1'b0;
    rst = 1'b1;
    idle(1);

    // Four consecutive bits 1,1,0,1, with no consumer.
    bits = 4'b1011;
    q4.push_back(4'b1011);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(bits[i], 1'b0);
      cnt = 2'(i + 1);
      checkOutput("cnt_seq", 32'(bit_cnt), 32'(cnt));
    end
    checkOutput("w1_valid", 32'(dout_valid), 1);
    idle(2);
    checkOutput("w1_hold", 32'(dout), 32'hb);
    // Consume with no new completion: valid drops and dout keeps its value.
    dout_ready = 1'b1;
    idle(1);
    dout_ready = 1'b0;
    checkOutput("consume_valid", 32'(dout_valid), 0);
    checkOutput("consume_dout", 32'(dout), 32'hb);

    // Gapped bits 0,1,1,0: the count holds during the gaps.
    bits = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q4.push_back(4'b0110);
      applyStimulus(bits[i], 1'b0);
      if (i < 3) begin
        idle(2);
        checkOutput("gap_hold", 32'(bit_cnt), 32'(i + 1));
      end
    end
    checkOutput("gap_valid", 32'(dout_valid), 1);
    checkOutput("gap_cnt", 32'(bit_cnt), 0);

    // Clear must win over a bit and a consume on the same edge.
    applyStimulus(1'b1, 1'b0);
    clear = 1'b1; sin = 1'b1; sin_valid = 1'b1; dout_ready = 1'b1;
    idle(1);
    clear = 1'b0; sin_valid = 1'b0; dout_ready = 1'b0;
    checkOutput("clr_pri_cnt", 32'(bit_cnt), 0);
    checkOutput("clr_pri_valid", 32'(dout_valid), 0);
    checkOutput("clr_pri_dout", 32'(dout), 0);

    // Overrun: A=1011 is held, then B=1010 completes and is dropped.
    bits = 4'b1011;
    q4.push_back(4'b1011);
    for (int i = 0; i < 4; i++) applyStimulus(bits[i], 1'b0);
    bits = 4'b1010;
    for (int i = 0; i < 4; i++) applyStimulus(bits[i], 1'b0);
    checkOutput("ovr_flag", 32'(overrun), 1);
    checkOutput("ovr_dout", 32'(dout), 32'hb);
    checkOutput("ovr_valid", 32'(dout_valid), 1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    idle(2);
    checkOutput("ovr_sticky", 32'(overrun), 1);
    checkOutput("ovr_continue", 32'(bit_cnt), 2);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    checkOutput("clr_overrun", 32'(overrun), 0);
    checkOutput("clr_dout", 32'(dout), 0);
    checkOutput("clr_valid", 32'(dout_valid), 0);
    checkOutput("clr_cnt", 32'(bit_cnt), 0);

    // Back to back: B completes on the same edge that A is consumed.
    bits = 4'b1011;
    q4.push_back(4'b1011);
    for (int i = 0; i < 4; i++) applyStimulus(bits[i], 1'b0);
    bits = 4'b0101;
    q4.push_back(4'b0101);
    for (int i = 0; i < 3; i++) applyStimulus(bits[i], 1'b0);
    dout_ready = 1'b1;
    applyStimulus(bits[3], 1'b0);
    dout_ready = 1'b0;
    checkOutput("b2b_valid", 32'(dout_valid), 1);
    checkOutput("b2b_dout", 32'(dout), 32'h5);
    checkOutput("b2b_overrun", 32'(overrun), 0);
    dout_ready = 1'b1;
    idle(1);
    checkOutput("b2b_drain", 32'(dout_valid), 0);
    // A consume while the buffer is empty has no effect.
    idle(2);
    dout_ready = 1'b0;
    checkOutput("empty_ready_valid", 32'(dout_valid), 0);
    checkOutput("empty_ready_dout", 32'(dout), 32'h5);

    // Reset mid-word discards the partial word.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("pre_rst_cnt", 32'(bit_cnt), 2);
    rst = 1'b0;
    #2;
    checkOutput("async_rst_cnt", 32'(bit_cnt), 0);
    checkOutput("async_rst_dout", 32'(dout), 0);
    #2;
    rst = 1'b1;
    idle(1);
    bits = 4'b1100;
    q4.push_back(4'b1100);
    for (int i = 0; i < 4; i++) applyStimulus(bits[i], 1'b0);
    checkOutput("post_rst_valid", 32'(dout_valid), 1);

    // Default width: the bits 1,0,0,0,0,0,0,0,0,1 arrive with the count stepping 1..9 and then 0.
    q10.push_back(10'b1000000001);
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i == 0 || i == 9) ? 1'b1 : 1'b0, 1'b1);
      checkOutput("cnt10_seq", 32'(bit_cnt10), (i == 9) ? 0 : 32'(i + 1));
    end
    checkOutput("w10_valid", 32'(dout_valid10), 1);
    idle(2);
    checkOutput("w10_dout", 32'(dout10), 32'h201);

    checkOutput("q4_drained", 32'(q4.size()), 0);
    checkOutput("q10_drained", 32'(q10.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 10, is the deserialized word width; legal range WIDTH >= 2.
REQ-002 Parameter CW, default $clog2(WIDTH), is the bit-counter width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 sin  input  1  serial data bit, LSB of word first.
REQ-006 sin_valid  input  1  qualifies sin; one bit is accepted per clk edge where it is high.
REQ-007 clear  input  1  synchronous flush of the receive path and status.
REQ-008 dout  output  WIDTH  assembled parallel word, registered.
REQ-009 dout_valid  output  1  dout holds an unconsumed word.
REQ-010 dout_ready  input  1  consumer accepts dout on an edge where dout_valid && dout_ready.
REQ-011 bit_cnt  output  CW  bits accepted into the current partial word, range 0..WIDTH-1.
REQ-012 overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 The shift path shall load each accepted bit at the MSB and shift right: sr <= {sin, sr[WIDTH-1:1]}.
REQ-014 The first accepted bit of a word shall end in dout[0] and the WIDTH-th in dout[WIDTH-1].
REQ-015 bit_cnt shall increment on each accepted bit and wrap from WIDTH-1 to 0 on the completing bit.
REQ-016 The receive FSM shall have states IDLE (bit_cnt==0) and SHIFT (bit_cnt>0).
REQ-017 IDLE->SHIFT occurs on an accepted bit; SHIFT->IDLE occurs on the completing bit.
REQ-018 No state changes when sin_valid is low; partial words are held indefinitely.
REQ-019 The output buffer FSM shall have states EMPTY (dout_valid=0) and FULL (dout_valid=1).
REQ-020 The completed word {sin, sr[WIDTH-1:1]} shall load into dout on the edge that samples the completing bit.
REQ-021 That load requires EMPTY, or FULL with dout_ready=1 on the same edge.
REQ-022 Latency: dout_valid rises on the same edge that samples the completing bit, one edge after the last sin_valid cycle begins.
REQ-023 Consume in FULL without a new completion: dout_valid shall be 0 after the edge, and dout keeps its last value.
REQ-024 Consume and completion on the same edge: dout_valid stays 1, dout takes the new word, and no overrun is flagged.
REQ-025 While dout_valid && !dout_ready, dout shall remain stable.
REQ-026 Completion while FULL with dout_ready=0: the new word is discarded, dout is unchanged, and overrun is set to 1.
REQ-027 Reception shall continue uninterrupted into the next word in both the overrun and back-to-back cases.
REQ-028 overrun shall clear only on rst or clear.
REQ-029 dout_ready while EMPTY shall have no effect.
REQ-030 clear=1 shall, on the next edge, zero sr, bit_cnt, dout, dout_valid and overrun.
REQ-031 clear has priority over sin_valid and dout_ready on the same edge.

Reset
REQ-032 rst=0 shall immediately force sr=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0, with both FSMs in IDLE/EMPTY.
REQ-033 rst deassertion mid-word shall discard the partial word; the first bit accepted after release is bit 0 of a new word.
REQ-034 No output shall change on a clk edge while rst=0.

Verification (bench WIDTH=4 unless noted)
REQ-035 Bits 1,1,0,1 on four consecutive sin_valid cycles, dout_ready=0 -> dout=4'b1011, dout_valid=1 after the 4th edge, bit_cnt back to 0.
REQ-036 Gapped sin_valid (bits 0,1,1,0 with idle cycles between) -> dout=4'b0110, and bit_cnt holds its value during gaps.
REQ-037 Word A=4'b1011 held with dout_ready=0, then word B completes -> overrun=1, dout stays 4'b1011; after clear, all outputs are 0.
REQ-038 dout_ready=1 on the completing edge of word B while A is valid -> dout=B, dout_valid stays 1, overrun=0.
REQ-039 rst pulsed low after 2 of 4 bits -> bit_cnt=0 immediately; the next 4 bits 0,0,1,1 give dout=4'b1100.
REQ-040 Default WIDTH=10, bits 1,0,0,0,0,0,0,0,0,1 -> dout=10'b1000000001, bit_cnt sequence 1..9 then 0.
